iic_target: RTL and testbench

Write-only I2C target (slave) for the WM8731-style control port. It oversamples SCL/SDA on the 50 MHz system clock and decodes START/STOP conditions. It matches a 7-bit device address, ACKs each accepted byte by pulling SDA low, and unpacks the two-byte WM8731 control word into a 7-bit register address and 9-bit data. It is the responder end of the existing IIC writer: the codec model in simulation, and an on-chip register-bank port in hardware.

---
 rtl/iic_pkg.sv | 21 ++
 rtl/iic_line_sync.sv | 32 +++
 rtl/iic_target.sv | 181 ++++++++++++++++++
 tb/tb_iic_target.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the WM8731-style I2C control port: state encodings,
// device address and framing constants.
package iic_pkg;

    typedef enum logic [4:0] {
        S_IDLE      = 5'd0,
        S_ADDR      = 5'd1,
        S_ADDR_ACK  = 5'd2,
        S_BYTE1     = 5'd3,
        S_ACK1      = 5'd4,
        S_BYTE2     = 5'd5,
        S_ACK2      = 5'd6,
        S_WAIT_STOP = 5'd7
    } iic_state_e;

    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

    localparam int unsigned BITS_PER_BYTE   = 8;
    localparam int unsigned BYTES_PER_FRAME = 3;

endpackage

// File: rtl/iic_line_sync.sv
// Two-flop synchronizer plus one delay flop for an I2C line; exposes the synced
// level and single-cycle rise/fall pulses.
module iic_line_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] pipe_q;
    logic [2:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1:0], line_i};
    end

    // Reset to the idle-bus level so no edge is reported coming out of reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= 3'b111;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign level_o = pipe_q[1];
    assign rise_o  = pipe_q[1] & ~pipe_q[2];
    assign fall_o  = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/iic_target.sv
// Write-only I2C target: decodes a 3-byte WM8731 control write into a 7-bit
// register address and 9-bit data, ACKing each accepted byte open-drain.
module iic_target
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = WM8731_DEV_ADDR
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_line_sync u_scl_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .line_i  (SCL),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    iic_line_sync u_sda_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .line_i  (SDA),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    iic_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic       seen_q, seen_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;

    // SCL must be high in both synced and delayed copies, so an SDA change
    // coinciding with an SCL rise counts as data rather than START/STOP.
    logic scl_high, start_det, stop_det, bit_end, last_bit;
    assign scl_high  = scl_lvl & ~scl_rise;
    assign start_det = sda_fall & scl_high;
    assign stop_det  = sda_rise & scl_high;
    // Only a fall preceded by a sampled rise ends a bit (skips the fall after START).
    assign bit_end   = scl_fall & seen_q;
    assign last_bit  = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        seen_d     = seen_q;
        shift_d    = shift_q;
        byte1_d    = byte1_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            seen_d  = 1'b1;
        end
        if (scl_fall) begin
            seen_d = 1'b0;
        end

        unique case (state_q)
            S_ADDR, S_BYTE1, S_BYTE2: begin
                if (bit_end) begin
                    bit_cnt_d = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                state_d  = S_ADDR_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else if (state_q == S_BYTE1) begin
                            state_d  = S_ACK1;
                            sda_oe_d = 1'b1;
                            byte1_d  = shift_q;
                        end else if (byte_cnt_q == 2'(BYTES_PER_FRAME - 1)) begin
                            state_d    = S_ACK2;
                            sda_oe_d   = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = byte1_q[7:1];
                            wr_data_d  = {byte1_q[0], shift_q};
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
            end
            S_ADDR_ACK, S_ACK1, S_ACK2: begin
                if (bit_end) begin
                    sda_oe_d   = 1'b0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == S_ADDR_ACK) begin
                        state_d = S_BYTE1;
                    end else if (state_q == S_ACK1) begin
                        state_d = S_BYTE2;
                    end else begin
                        state_d = S_WAIT_STOP;
                    end
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            seen_d     = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            wr_valid_d = 1'b0;
            wr_addr_d  = wr_addr_q;
            wr_data_d  = wr_data_q;
        end else if (stop_det) begin
            state_d    = S_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            wr_valid_d = 1'b0;
            wr_addr_d  = wr_addr_q;
            wr_data_d  = wr_data_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            seen_q     <= 1'b0;
            shift_q    <= 8'd0;
            byte1_q    <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            seen_q     <= seen_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: the bench plays the I2C writer, with a pull-up
// on SDA so a released line reads 1 and a target ACK reads 0.
module tb_iic_target;

    localparam int Q = 10;  // quarter SCL period in clk_in cycles

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCL = 1'b1;
    logic       tb_sda_low = 1'b0;
    wire        SDA;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;

    assign SDA = tb_sda_low ? 1'b0 : 1'bz;
    pullup (SDA);

    iic_target dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .SCL      (SCL),
        .SDA      (SDA),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #10 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int v0;
    logic a0, a1, a2, a3;

    // Counts high cycles, so a pulse wider than one cycle inflates the count.
    always @(negedge clk_in) begin
        if (wr_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        idle(Q);
        SCL = 1'b1;
        idle(Q);
        tb_sda_low = 1'b1;
        idle(Q);
        SCL = 1'b0;
        idle(Q);
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1;
        idle(Q);
        SCL = 1'b1;
        idle(Q);
        tb_sda_low = 1'b0;
        idle(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tb_sda_low = ~b;
        idle(Q);
        SCL = 1'b1;
        idle(2 * Q);
        SCL = 1'b0;
        idle(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        tb_sda_low = 1'b0;
        idle(Q);
        SCL = 1'b1;
        idle(Q);
        ack_n = SDA;
        idle(Q);
        SCL = 1'b0;
        idle(Q);
    endtask

    initial begin
        idle(3);
        check("reset_sda", {15'd0, SDA}, 16'h1);
        check("reset_valid", {15'd0, wr_valid}, 16'h0);
        check("reset_addr", {9'd0, wr_addr}, 16'h0);
        check("reset_data", {7'd0, wr_data}, 16'h0);
        check("reset_busy", {15'd0, busy}, 16'h0);
        rst_n = 1'b1;
        idle(5);

        // 0x34,0x1E,0x00 -> reg 0x0F, data 0x000
        v0 = valid_cnt;
        i2c_start();
        check("t1_busy_set", {15'd0, busy}, 16'h1);
        send_byte(8'h34, a0);
        send_byte(8'h1E, a1);
        send_byte(8'h00, a2);
        i2c_stop();
        check("t1_ack0", {15'd0, a0}, 16'h0);
        check("t1_ack1", {15'd0, a1}, 16'h0);
        check("t1_ack2", {15'd0, a2}, 16'h0);
        check("t1_valid_cnt", 16'(valid_cnt - v0), 16'd1);
        check("t1_addr", {9'd0, wr_addr}, 16'h0F);
        check("t1_data", {7'd0, wr_data}, 16'h000);
        check("t1_busy_clr", {15'd0, busy}, 16'h0);

        // 0x34,0x09,0xFF -> reg 0x04, data 0x1FF
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h09, a1);
        send_byte(8'hFF, a2);
        i2c_stop();
        check("t2_ack2", {15'd0, a2}, 16'h0);
        check("t2_valid_cnt", 16'(valid_cnt - v0), 16'd1);
        check("t2_addr", {9'd0, wr_addr}, 16'h04);
        check("t2_data", {7'd0, wr_data}, 16'h1FF);

        // Wrong address and read bit: NACK, outputs untouched
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h36, a0);
        i2c_stop();
        i2c_start();
        send_byte(8'h35, a1);
        send_byte(8'h09, a2);
        i2c_stop();
        check("t3_nack_0x36", {15'd0, a0}, 16'h1);
        check("t3_nack_0x35", {15'd0, a1}, 16'h1);
        check("t3_nack_data", {15'd0, a2}, 16'h1);
        check("t3_valid_cnt", 16'(valid_cnt - v0), 16'd0);
        check("t3_addr", {9'd0, wr_addr}, 16'h04);
        check("t3_data", {7'd0, wr_data}, 16'h1FF);

        // Extra 4th byte is NACKed, write reported once
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h1E, a1);
        send_byte(8'h00, a2);
        send_byte(8'hAA, a3);
        i2c_stop();
        check("t4_ack2", {15'd0, a2}, 16'h0);
        check("t4_nack3", {15'd0, a3}, 16'h1);
        check("t4_valid_cnt", 16'(valid_cnt - v0), 16'd1);
        check("t4_addr", {9'd0, wr_addr}, 16'h0F);
        check("t4_data", {7'd0, wr_data}, 16'h000);

        // Partial frame aborted by repeated START, then 0x34,0x0C,0x02
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0E, a1);
        i2c_start();
        check("t5_busy_rs", {15'd0, busy}, 16'h1);
        send_byte(8'h34, a0);
        send_byte(8'h0C, a1);
        send_byte(8'h02, a2);
        i2c_stop();
        check("t5_ack2", {15'd0, a2}, 16'h0);
        check("t5_valid_cnt", 16'(valid_cnt - v0), 16'd1);
        check("t5_addr", {9'd0, wr_addr}, 16'h06);
        check("t5_data", {7'd0, wr_data}, 16'h002);

        // Asynchronous reset while the target drives ACK1
        i2c_start();
        send_byte(8'h34, a0);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        tb_sda_low = 1'b0;
        idle(2);
        check("t6_ack1_drive", {15'd0, SDA}, 16'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda", {15'd0, SDA}, 16'h1);
        check("t6_rst_addr", {9'd0, wr_addr}, 16'h0);
        check("t6_rst_data", {7'd0, wr_data}, 16'h0);
        check("t6_rst_busy", {15'd0, busy}, 16'h0);
        check("t6_rst_valid", {15'd0, wr_valid}, 16'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        i2c_stop();
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h09, a1);
        send_byte(8'hFF, a2);
        i2c_stop();
        check("t6_ack0", {15'd0, a0}, 16'h0);
        check("t6_valid_cnt", 16'(valid_cnt - v0), 16'd1);
        check("t6_addr", {9'd0, wr_addr}, 16'h04);
        check("t6_data", {7'd0, wr_data}, 16'h1FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
